// File: rtl/core_sequencer_if.sv
// Memory read bus between the sequencer (master) and instruction memory (slave).
// bus_ack is a one-cycle pulse; bus_datain is valid only while bus_ack is high.
interface core_sequencer_if;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic [15:0] bus_datain;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_datain,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_datain,
    output bus_ack
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/execute controller for the core register file.
// Register map: r0..r10 general purpose, r11 PC, r12..r14 constants, r15 bus latch.
// Instruction word: [15:12] opcode, [11:8] dst, [7:4] src, [3:0] unused.
// All outputs are combinational from state, IR and inputs; rst forces them idle.
module core_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  core_sequencer_if.master         bus,
  input  logic [15:0]              pc_in,
  input  logic [15:0]              rf_data_read,
  output logic [3:0]               rf_addr_read,
  output logic [3:0]               rf_addr_write,
  output logic [15:0]              rf_data_write,
  output logic                     rf_write_enable,
  output logic                     rf_bus_fromin,
  output logic                     rf_pc_inc,
  output logic                     halted,
  output logic                     fault,
  output logic                     illegal,
  output logic [15:0]              retired
);

  typedef enum logic [2:0] {
    StFetch,
    StExec,
    StFetchImm,
    StWriteImm,
    StHalt,
    StFault
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpMov  = 4'h1;
  localparam logic [3:0] OpInc  = 4'h2;
  localparam logic [3:0] OpLdi  = 4'h3;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [3:0] RegBusLatch = 4'd15;

  // Last request cycle without ack that is still tolerated; the next one is the fault.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] retired_q, retired_d;

  logic [3:0] op;
  logic [3:0] dst;
  logic [3:0] src;
  logic       unused_ir;

  assign op        = ir_q[15:12];
  assign dst       = ir_q[11:8];
  assign src       = ir_q[7:4];
  assign unused_ir = ^ir_q[3:0];

  // State, instruction register, bus-timeout counter and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
    end
  end

  // Next-state decode and register-file / bus control generation.
  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    tmo_d           = tmo_q;
    retired_d       = retired_q;
    bus.bus_req     = 1'b0;
    bus.bus_addr    = pc_in;
    rf_addr_read    = '0;
    rf_addr_write   = '0;
    rf_data_write   = '0;
    rf_write_enable = 1'b0;
    rf_bus_fromin   = 1'b0;
    rf_pc_inc       = 1'b0;
    illegal         = 1'b0;

    unique case (state_q)
      StFetch, StFetchImm: begin
        bus.bus_req = 1'b1;
        if (bus.bus_ack) begin
          // The fetched word always lands in the bus latch; PC steps past it.
          rf_bus_fromin = 1'b1;
          rf_pc_inc     = 1'b1;
          tmo_d         = '0;
          if (state_q == StFetch) begin
            ir_d    = bus.bus_datain;
            state_d = StExec;
          end else begin
            state_d = StWriteImm;
          end
        end else if (tmo_q == TmoLast) begin
          tmo_d   = '0;
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      StExec: begin
        rf_addr_read = src;
        state_d      = StFetch;
        retired_d    = retired_q + 16'd1;
        case (op)
          OpNop: ;
          OpMov: begin
            rf_addr_write   = dst;
            rf_data_write   = rf_data_read;
            rf_write_enable = 1'b1;
          end
          OpInc: begin
            rf_addr_write   = dst;
            rf_data_write   = rf_data_read + 16'd1;
            rf_write_enable = 1'b1;
          end
          OpLdi: begin
            // Retires only once the immediate has been written.
            retired_d = retired_q;
            state_d   = StFetchImm;
          end
          OpHalt: state_d = StHalt;
          default: illegal = 1'b1;
        endcase
      end

      StWriteImm: begin
        rf_addr_read    = RegBusLatch;
        rf_addr_write   = dst;
        rf_data_write   = rf_data_read;
        rf_write_enable = 1'b1;
        retired_d       = retired_q + 16'd1;
        state_d         = StFetch;
      end

      StHalt, StFault: ;

      default: state_d = StFetch;
    endcase

    // Reset abandons the instruction and drops any request in the same cycle.
    if (rst) begin
      bus.bus_req     = 1'b0;
      rf_addr_read    = '0;
      rf_addr_write   = '0;
      rf_data_write   = '0;
      rf_write_enable = 1'b0;
      rf_bus_fromin   = 1'b0;
      rf_pc_inc       = 1'b0;
      illegal         = 1'b0;
    end
  end

  // Status outputs, forced idle while rst is held.
  always_comb begin
    halted  = (state_q == StHalt) && !rst;
    fault   = (state_q == StFault) && !rst;
    retired = rst ? 16'd0 : retired_q;
  end

  // A PC write and a PC increment in the same cycle would race inside the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rf_pc_inc && rf_write_enable));
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: behavioural register file and memory around the DUT,
// expected register writes queued by the stimulus and checked by a write monitor.
module tb_core_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] pc_in;
  logic [15:0] rf_data_read;
  logic [3:0]  rf_addr_read;
  logic [3:0]  rf_addr_write;
  logic [15:0] rf_data_write;
  logic        rf_write_enable;
  logic        rf_bus_fromin;
  logic        rf_pc_inc;
  logic        halted;
  logic        fault;
  logic        illegal;
  logic [15:0] retired;

  core_sequencer_if bus_if ();

  core_sequencer #(
    .TIMEOUT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .pc_in          (pc_in),
    .rf_data_read   (rf_data_read),
    .rf_addr_read   (rf_addr_read),
    .rf_addr_write  (rf_addr_write),
    .rf_data_write  (rf_data_write),
    .rf_write_enable(rf_write_enable),
    .rf_bus_fromin  (rf_bus_fromin),
    .rf_pc_inc      (rf_pc_inc),
    .halted         (halted),
    .fault          (fault),
    .illegal        (illegal),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Environment: memory, register file and an ack responder with programmable wait.
  logic [15:0] mem       [256];
  logic [15:0] init_regs [16];
  logic [15:0] regs      [16];
  int unsigned ack_delay;
  logic [15:0] wait_cnt;

  assign bus_if.bus_datain = mem[bus_if.bus_addr[7:0]];
  assign bus_if.bus_ack    = bus_if.bus_req && (ack_delay != 0) &&
                             (32'(wait_cnt) + 1 == ack_delay);
  assign pc_in             = regs[11];
  assign rf_data_read      = regs[rf_addr_read];

  always @(posedge clk) begin
    if (rst || !bus_if.bus_req || bus_if.bus_ack) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 16'd1;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_regs[i];
    end else begin
      if (rf_write_enable && rf_addr_write < 4'd12) regs[rf_addr_write] <= rf_data_write;
      if (rf_pc_inc) regs[11] <= regs[11] + 16'd1;
      if (rf_bus_fromin) regs[15] <= bus_if.bus_datain;
    end
  end

  // Scoreboard of expected register-file writes.
  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  always @(negedge clk) begin
    if (!rst && rf_write_enable) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write",
                 rf_addr_write, rf_data_write);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(rf_addr_write), 32'(mon_e.addr));
        check("wr_data", 32'(rf_data_write), 32'(mon_e.data));
        check("wr_no_pc_inc", 32'(rf_pc_inc), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) init_regs[i] = 16'h0000;
    init_regs[13] = 16'h0001;
    init_regs[14] = 16'hFFFF;
  endtask

  // Holds reset for two edges, checks the idle outputs, then releases into cycle 1.
  task automatic start();
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_req", 32'(bus_if.bus_req), 32'd0);
    check("rst_ctrl", 32'({rf_write_enable, rf_pc_inc, rf_bus_fromin, illegal}), 32'd0);
    check("rst_status", 32'({halted, fault}), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_addr", 32'(bus_if.bus_addr), 32'd0);
  endtask

  task automatic wait_halt(input int bound);
    int k;
    k = 0;
    while (!halted && k < bound) begin
      cyc();
      k++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int req_cnt;
  int ill_cnt;

  initial begin
    rst       = 1'b1;
    ack_delay = 1;
    clear_env();

    // 1: MOV r1,r2 with zero-wait ack.
    mem[0]       = 16'h1120;
    mem[1]       = 16'hF000;
    init_regs[2] = 16'hBEEF;
    exp_q.push_back(wr_t'{addr: 4'd1, data: 16'hBEEF});
    start();
    check("t1_req", 32'(bus_if.bus_req), 32'd1);
    check("t1_addr", 32'(bus_if.bus_addr), 32'd0);
    check("t1_fetch_ctrl", 32'({rf_bus_fromin, rf_pc_inc}), 32'h3);
    cyc();
    check("t1_we", 32'(rf_write_enable), 32'd1);
    check("t1_addr_read", 32'(rf_addr_read), 32'd2);
    cyc();
    check("t1_retired", 32'(retired), 32'd1);
    check("t1_pc", 32'(bus_if.bus_addr), 32'd1);
    wait_halt(20);
    check("t1_retired_end", 32'(retired), 32'd2);

    // 2: LDI r5 with three-cycle ack on both fetches.
    clear_env();
    mem[0]    = 16'h3500;
    mem[1]    = 16'h1234;
    mem[2]    = 16'hF000;
    ack_delay = 3;
    exp_q.push_back(wr_t'{addr: 4'd5, data: 16'h1234});
    start();
    check("t2_c1", 32'({bus_if.bus_req, bus_if.bus_ack}), 32'h2);
    cyc();
    check("t2_c2", 32'({bus_if.bus_req, bus_if.bus_ack}), 32'h2);
    cyc();
    check("t2_c3", 32'({bus_if.bus_req, bus_if.bus_ack}), 32'h3);
    cyc();
    check("t2_exec", 32'({bus_if.bus_req, rf_write_enable}), 32'h0);
    cyc();
    check("t2_imm_addr", 32'(bus_if.bus_addr), 32'd1);
    cyc();
    cyc();
    check("t2_imm_ack", 32'({bus_if.bus_req, bus_if.bus_ack}), 32'h3);
    cyc();
    check("t2_wimm_read", 32'(rf_addr_read), 32'd15);
    check("t2_wimm_ctrl", 32'({rf_write_enable, rf_pc_inc}), 32'h2);
    cyc();
    check("t2_pc", 32'(bus_if.bus_addr), 32'd2);
    check("t2_retired", 32'(retired), 32'd1);
    wait_halt(30);
    check("t2_r5", 32'(regs[5]), 32'h1234);

    // 3: INC wraps, MOV to r11 jumps.
    clear_env();
    mem[0]       = 16'h2330;
    mem[1]       = 16'h1B40;
    mem[8'h40]   = 16'hF000;
    init_regs[3] = 16'hFFFF;
    init_regs[4] = 16'h0040;
    ack_delay    = 1;
    exp_q.push_back(wr_t'{addr: 4'd3, data: 16'h0000});
    exp_q.push_back(wr_t'{addr: 4'd11, data: 16'h0040});
    start();
    cyc();
    check("t3_inc_wrap", 32'(rf_data_write), 32'h0000);
    cyc();
    cyc();
    check("t3_jump_ctrl", 32'({rf_write_enable, rf_pc_inc}), 32'h2);
    cyc();
    check("t3_jump_addr", 32'(bus_if.bus_addr), 32'h0040);
    wait_halt(20);
    check("t3_retired", 32'(retired), 32'd3);

    // 4: illegal opcode then HALT; halt is sticky.
    clear_env();
    mem[0] = 16'h7000;
    mem[1] = 16'hF000;
    start();
    ill_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (illegal) ill_cnt++;
      if (i == 1) check("t4_ill_cycle", 32'({illegal, rf_write_enable}), 32'h2);
      cyc();
    end
    check("t4_ill_once", 32'(ill_cnt), 32'd1);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_retired", 32'(retired), 32'd2);
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.bus_req || illegal || rf_bus_fromin || rf_pc_inc) req_cnt++;
      cyc();
    end
    check("t4_quiet", 32'(req_cnt), 32'd0);
    check("t4_still_halted", 32'(halted), 32'd1);

    // 5a: no ack ever, TIMEOUT=4.
    clear_env();
    ack_delay = 0;
    start();
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.bus_req) req_cnt++;
      cyc();
    end
    check("t5_req_cycles", 32'(req_cnt), 32'd4);
    check("t5_fault", 32'({fault, halted, bus_if.bus_req}), 32'h4);

    // 5b: ack on the fourth request cycle wins over the timeout.
    clear_env();
    mem[0]    = 16'h0000;
    mem[1]    = 16'hF000;
    ack_delay = 4;
    start();
    wait_halt(40);
    check("t5b_no_fault", 32'(fault), 32'd0);
    check("t5b_retired", 32'(retired), 32'd2);

    // 6: reset during FETCH_IMM of LDI discards the load.
    clear_env();
    mem[0]       = 16'h3500;
    mem[1]       = 16'h1234;
    mem[2]       = 16'hF000;
    init_regs[5] = 16'h5555;
    ack_delay    = 3;
    start();
    for (int i = 0; i < 4; i++) cyc();
    check("t6_in_imm", 32'({bus_if.bus_req, bus_if.bus_addr}), 32'h10001);
    mem[0] = 16'hF000;
    rst    = 1'b1;
    #1;
    check("t6_req_drop", 32'(bus_if.bus_req), 32'd0);
    check("t6_ctrl_drop", 32'({rf_write_enable, rf_pc_inc, rf_bus_fromin}), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check("t6_fetch", 32'({bus_if.bus_req, bus_if.bus_addr}), 32'h10000);
    check("t6_ctrl", 32'({rf_write_enable, rf_pc_inc, rf_bus_fromin}), 32'd0);
    check("t6_retired", 32'(retired), 32'd0);
    wait_halt(30);
    check("t6_r5_kept", 32'(regs[5]), 32'h5555);
    check("t6_retired_end", 32'(retired), 32'd1);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
